// File: rtl/line_fill_ctrl.sv
// line_fill_ctrl
//   Data-memory port controller that sits directly behind the direct-mapped
//   data cache. It breaks one 128-bit line transaction (read-fill or
//   write-back) into four sequential 32-bit word accesses. An optional initial
//   wait models slow memory. The finished line is returned through a
//   valid/ack handshake.
//
// Ports
//   CLK, RST                 clock; asynchronous active-high reset
//   REQ_VALID/REQ_READY      line request handshake from the cache
//   REQ_WR                   1 = write line to memory, 0 = fill line from memory
//   REQ_ADDR[AW-1:0]         line byte address (bits [3:0] ignored)
//   REQ_WDATA[127:0]         write line, word0 in [127:96] ... word3 in [31:0]
//   RESP_VALID/RESP_ACK      completion handshake back to the cache
//   RESP_RDATA[127:0]        assembled fill line, same word ordering
//   BUSY                     high from acceptance until the response is acked
//   D_MEM_CSN, D_MEM_WEN     memory chip select / write enable, active-low
//   D_MEM_ADDR[AW-1:0]       word byte address
//   D_MEM_DOUT[31:0]         write data to memory
//   D_MEM_DI[31:0]           combinational read data from memory
module line_fill_ctrl #(
  parameter int unsigned LAT = 3,
  parameter int unsigned AW  = 12
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          REQ_VALID,
  output logic          REQ_READY,
  input  logic          REQ_WR,
  input  logic [AW-1:0] REQ_ADDR,
  input  logic [127:0]  REQ_WDATA,
  output logic          RESP_VALID,
  input  logic          RESP_ACK,
  output logic [127:0]  RESP_RDATA,
  output logic          BUSY,
  output logic          D_MEM_CSN,
  output logic          D_MEM_WEN,
  output logic [AW-1:0] D_MEM_ADDR,
  output logic [31:0]   D_MEM_DOUT,
  input  logic [31:0]   D_MEM_DI
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_XFER,
    S_RESP
  } state_e;

  localparam logic [3:0] LCNT_INIT = 4'(LAT - 1);

  state_e         state_q, state_d;
  logic           wr_q, wr_d;
  logic [AW-5:0]  line_q, line_d;
  logic [127:0]   wdata_q, wdata_d;
  logic [127:0]   rdata_q, rdata_d;
  logic [1:0]     wcnt_q, wcnt_d;
  logic [3:0]     lcnt_q, lcnt_d;

  assign REQ_READY  = (state_q == S_IDLE) && !RST;
  assign BUSY       = (state_q != S_IDLE);
  assign RESP_VALID = (state_q == S_RESP);
  assign RESP_RDATA = rdata_q;

  always_comb begin
    state_d    = state_q;
    wr_d       = wr_q;
    line_d     = line_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    wcnt_d     = wcnt_q;
    lcnt_d     = lcnt_q;
    D_MEM_CSN  = 1'b1;
    D_MEM_WEN  = 1'b1;
    D_MEM_ADDR = '0;
    D_MEM_DOUT = '0;

    case (state_q)
      S_IDLE: begin
        if (REQ_VALID && REQ_READY) begin
          wr_d    = REQ_WR;
          line_d  = REQ_ADDR[AW-1:4];
          wdata_d = REQ_WDATA;
          wcnt_d  = '0;
          lcnt_d  = LCNT_INIT;
          state_d = (LAT == 0) ? S_XFER : S_WAIT;
        end
      end

      S_WAIT: begin
        if (lcnt_q == '0) begin
          state_d = S_XFER;
        end else begin
          lcnt_d = lcnt_q - 4'd1;
        end
      end

      S_XFER: begin
        D_MEM_CSN  = 1'b0;
        D_MEM_ADDR = {line_q, wcnt_q, 2'b00};
        // Word n sits at bit offset (3-n)*32; for a 2-bit index, 3-n is ~n.
        if (wr_q) begin
          D_MEM_WEN  = 1'b0;
          D_MEM_DOUT = wdata_q[{~wcnt_q, 5'b00000} +: 32];
        end else begin
          rdata_d[{~wcnt_q, 5'b00000} +: 32] = D_MEM_DI;
        end
        wcnt_d = wcnt_q + 2'd1;
        if (wcnt_q == 2'd3) begin
          state_d = S_RESP;
        end
      end

      S_RESP: begin
        if (RESP_ACK) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      wr_q    <= 1'b0;
      line_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      wcnt_q  <= '0;
      lcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      line_q  <= line_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      wcnt_q  <= wcnt_d;
      lcnt_q  <= lcnt_d;
    end
  end

endmodule

// File: tb/tb_line_fill_ctrl.sv
// Testbench for line_fill_ctrl. Two instances are used: one with LAT=3 and
// one with LAT=0. A select line routes the stimulus and the shared memory to
// one of them at a time. A transaction-age model predicts every output on
// every cycle. Directed tests also pin literal values.
`timescale 1ns/1ps
module tb_line_fill_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sel = 1'b0;                 // 0: LAT=3 instance, 1: LAT=0 instance

  logic         req_valid = 1'b0;
  logic         req_wr    = 1'b0;
  logic [11:0]  req_addr  = '0;
  logic [127:0] req_wdata = '0;
  logic         resp_ack  = 1'b0;

  logic         bd_we   = 1'b0;     // backdoor preload of the memory
  logic [11:0]  bd_addr = '0;
  logic [31:0]  bd_data = '0;

  always #5 clk = ~clk;

  // per-instance outputs
  logic a_ready, a_rv, a_busy, a_csn, a_wen;
  logic b_ready, b_rv, b_busy, b_csn, b_wen;
  logic [11:0]  a_addr, b_addr;
  logic [31:0]  a_dout, b_dout, a_di, b_di;
  logic [127:0] a_rdata, b_rdata;

  // selected view
  logic         req_ready, resp_valid, busy, csn, wen;
  logic [11:0]  d_addr;
  logic [31:0]  d_dout;
  logic [127:0] resp_rdata;

  assign req_ready  = sel ? b_ready : a_ready;
  assign resp_valid = sel ? b_rv    : a_rv;
  assign busy       = sel ? b_busy  : a_busy;
  assign csn        = sel ? b_csn   : a_csn;
  assign wen        = sel ? b_wen   : a_wen;
  assign d_addr     = sel ? b_addr  : a_addr;
  assign d_dout     = sel ? b_dout  : a_dout;
  assign resp_rdata = sel ? b_rdata : a_rdata;

  logic [31:0] mem [0:1023];
  assign a_di = mem[a_addr[11:2]];
  assign b_di = mem[b_addr[11:2]];

  always @(posedge clk) begin
    if (bd_we) mem[bd_addr[11:2]] <= bd_data;
    else if (!csn && !wen) mem[d_addr[11:2]] <= d_dout;
  end

  line_fill_ctrl #(.LAT(3), .AW(12)) u_dut_lat3 (
    .CLK(clk), .RST(rst),
    .REQ_VALID(req_valid && !sel), .REQ_READY(a_ready), .REQ_WR(req_wr),
    .REQ_ADDR(req_addr), .REQ_WDATA(req_wdata),
    .RESP_VALID(a_rv), .RESP_ACK(resp_ack && !sel), .RESP_RDATA(a_rdata),
    .BUSY(a_busy), .D_MEM_CSN(a_csn), .D_MEM_WEN(a_wen),
    .D_MEM_ADDR(a_addr), .D_MEM_DOUT(a_dout), .D_MEM_DI(a_di)
  );

  line_fill_ctrl #(.LAT(0), .AW(12)) u_dut_lat0 (
    .CLK(clk), .RST(rst),
    .REQ_VALID(req_valid && sel), .REQ_READY(b_ready), .REQ_WR(req_wr),
    .REQ_ADDR(req_addr), .REQ_WDATA(req_wdata),
    .RESP_VALID(b_rv), .RESP_ACK(resp_ack && sel), .RESP_RDATA(b_rdata),
    .BUSY(b_busy), .D_MEM_CSN(b_csn), .D_MEM_WEN(b_wen),
    .D_MEM_ADDR(b_addr), .D_MEM_DOUT(b_dout), .D_MEM_DI(b_di)
  );

  // ---------------- behavioural model ----------------
  // A transaction is described by its age: cycle 1 is the first cycle after
  // the acceptance edge. Ages 1..LAT are waiting, ages LAT+1..LAT+4 access
  // words 0..3, and ages of LAT+5 and above are the response.
  int           m_lat;
  logic         m_busy = 1'b0;
  int           m_age  = 0;
  logic         m_wr   = 1'b0;
  logic [11:0]  m_base = '0;
  logic [127:0] m_wdata = '0;
  logic [127:0] m_rdata = '0;
  logic [31:0]  ref_mem [0:1023];

  always_comb m_lat = sel ? 0 : 3;

  function automatic logic [31:0] word_of(input logic [127:0] l, input int i);
    return l[(3 - i) * 32 +: 32];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy  <= 1'b0;
      m_age   <= 0;
      m_wr    <= 1'b0;
      m_base  <= '0;
      m_wdata <= '0;
      m_rdata <= '0;
    end else begin
      if (bd_we) ref_mem[bd_addr[11:2]] <= bd_data;
      if (!m_busy) begin
        if (req_valid) begin
          m_busy  <= 1'b1;
          m_age   <= 1;
          m_wr    <= req_wr;
          m_base  <= {req_addr[11:4], 4'h0};
          m_wdata <= req_wdata;
        end
      end else begin
        if (m_age >= m_lat + 1 && m_age <= m_lat + 4) begin
          if (m_wr)
            ref_mem[10'(int'(m_base[11:2]) + m_age - m_lat - 1)] <= word_of(m_wdata, m_age - m_lat - 1);
          else
            m_rdata[(m_lat + 4 - m_age) * 32 +: 32] <= ref_mem[10'(int'(m_base[11:2]) + m_age - m_lat - 1)];
        end
        if (m_age >= m_lat + 5) begin
          if (resp_ack) m_busy <= 1'b0;
        end else begin
          m_age <= m_age + 1;
        end
      end
    end
  end

  // ---------------- checking ----------------
  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic compare_model();
    logic x;
    int w;
    logic [11:0] ea;
    logic [31:0] ed;
    x  = m_busy && (m_age >= m_lat + 1) && (m_age <= m_lat + 4);
    w  = m_age - m_lat - 1;
    ea = x ? (m_base + 12'(4 * w)) : 12'h000;
    ed = (x && m_wr) ? word_of(m_wdata, w) : 32'h0;
    chk("m_req_ready",  128'(req_ready),  128'(!m_busy && !rst));
    chk("m_busy",       128'(busy),       128'(m_busy));
    chk("m_resp_valid", 128'(resp_valid), 128'(m_busy && m_age >= m_lat + 5));
    chk("m_csn",        128'(csn),        128'(!x));
    chk("m_wen",        128'(wen),        128'(!(x && m_wr)));
    chk("m_addr",       128'(d_addr),     128'(ea));
    chk("m_dout",       128'(d_dout),     128'(ed));
    if (!m_busy || m_age >= m_lat + 5)
      chk("m_rdata", resp_rdata, m_rdata);
  endtask

  task automatic slot();
    @(negedge clk);
    compare_model();
    #2;
  endtask

  task automatic preload(input logic [11:0] a, input logic [31:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    slot();
    bd_we = 1'b0;
  endtask

  int           resp_cyc;
  logic [127:0] resp_line;
  logic         seen_csn  [0:63];
  logic         seen_wen  [0:63];
  logic [11:0]  seen_addr [0:63];
  logic [31:0]  seen_dout [0:63];

  // Presents a request in the current cycle, records the memory port per
  // cycle, waits for the response, holds off the ack for ack_delay cycles and
  // returns in the first cycle after the ack edge.
  task automatic run_txn(input logic wr, input logic [11:0] addr, input logic [127:0] wd,
                         input int ack_delay, input logic keep_req);
    int n;
    req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wd;
    slot();
    if (!keep_req) req_valid = 1'b0;
    n = 1;
    resp_cyc = -1;
    while (n < 64 && resp_cyc < 0) begin
      seen_csn[n]  = csn;
      seen_wen[n]  = wen;
      seen_addr[n] = d_addr;
      seen_dout[n] = d_dout;
      if (resp_valid) resp_cyc = n;
      else begin
        slot();
        n++;
      end
    end
    if (resp_cyc < 0) begin
      tests++;
      fails++;
      $display("FAIL resp_timeout: no RESP_VALID after %0d cycles, required within 64", n);
    end
    resp_line = resp_rdata;
    for (int i = 0; i < ack_delay; i++) begin
      chk("hold_valid", 128'(resp_valid), 128'(1));
      chk("hold_ready", 128'(req_ready),  128'(0));
      slot();
    end
    resp_ack = 1'b1;
    slot();
    resp_ack = 1'b0;
  endtask

  localparam logic [127:0] W2 = 128'hDEADBEEF_00000001_00000002_CAFEF00D;
  localparam logic [127:0] W5 = 128'h12345678_9ABCDEF0_0BADF00D_FEEDFACE;
  localparam logic [127:0] W6 = 128'hAAAAAAAA_A1A1A1A1_A2A2A2A2_A3A3A3A3;
  localparam logic [127:0] L1 = 128'h11111111_22222222_33333333_44444444;

  initial begin
    #1 rst = 1'b1;
    slot();
    slot();
    chk("rst_req_ready", 128'(req_ready),  128'(0));
    chk("rst_busy",      128'(busy),       128'(0));
    chk("rst_csn",       128'(csn),        128'(1));
    chk("rst_wen",       128'(wen),        128'(1));
    chk("rst_addr",      128'(d_addr),     128'(0));
    chk("rst_dout",      128'(d_dout),     128'(0));
    chk("rst_resp_valid",128'(resp_valid), 128'(0));
    chk("rst_rdata",     resp_rdata,       128'(0));
    rst = 1'b0;
    slot();
    chk("idle_ready", 128'(req_ready), 128'(1));

    for (int i = 0; i < 4; i++) begin
      preload(12'(12'h040 + 4 * i), 32'h11111111 * (i + 1));
      preload(12'(12'h000 + 4 * i), 32'hA0000000 + i);
      preload(12'(12'h100 + 4 * i), 32'hB0000000 + i);
      preload(12'(12'h200 + 4 * i), 32'h55550000 + i);
    end

    // 1: read fill, LAT=3
    run_txn(1'b0, 12'h047, '0, 0, 1'b0);
    chk("t1_resp_cycle", 128'(resp_cyc), 128'(8));
    chk("t1_wait_csn",   128'(seen_csn[3]), 128'(1));
    for (int i = 0; i < 4; i++) begin
      chk("t1_addr", 128'(seen_addr[4 + i]), 128'(12'h040 + 4 * i));
      chk("t1_csn",  128'(seen_csn[4 + i]),  128'(0));
      chk("t1_wen",  128'(seen_wen[4 + i]),  128'(1));
    end
    chk("t1_line", resp_line, L1);

    // 2: write line, LAT=3
    run_txn(1'b1, 12'h3F0, W2, 0, 1'b0);
    chk("t2_resp_cycle", 128'(resp_cyc), 128'(8));
    chk("t2_wen0", 128'(seen_wen[4]),  128'(0));
    chk("t2_wen3", 128'(seen_wen[7]),  128'(0));
    chk("t2_addr0",128'(seen_addr[4]), 128'(12'h3F0));
    chk("t2_addr3",128'(seen_addr[7]), 128'(12'h3FC));
    chk("t2_dout0",128'(seen_dout[4]), 128'(32'hDEADBEEF));
    chk("t2_dout1",128'(seen_dout[5]), 128'(32'h00000001));
    chk("t2_dout2",128'(seen_dout[6]), 128'(32'h00000002));
    chk("t2_dout3",128'(seen_dout[7]), 128'(32'hCAFEF00D));
    chk("t2_mem0", 128'(mem[252]), 128'(32'hDEADBEEF));
    chk("t2_mem3", 128'(mem[255]), 128'(32'hCAFEF00D));
    run_txn(1'b0, 12'h3F0, '0, 0, 1'b0);
    chk("t2_readback", resp_line, W2);

    // 3: LAT=0 instance, read of 0x000
    rst = 1'b1; sel = 1'b1;
    slot();
    rst = 1'b0;
    slot();
    run_txn(1'b0, 12'h000, '0, 0, 1'b0);
    chk("t3_resp_cycle", 128'(resp_cyc), 128'(5));
    chk("t3_csn_c1",  128'(seen_csn[1]),  128'(0));
    chk("t3_addr_c2", 128'(seen_addr[2]), 128'(12'h004));
    chk("t3_addr_c4", 128'(seen_addr[4]), 128'(12'h00C));
    chk("t3_line", resp_line, 128'hA0000000_A0000001_A0000002_A0000003);
    rst = 1'b1; sel = 1'b0;
    slot();
    rst = 1'b0;
    slot();

    // 4: delayed ack with a second request held high
    run_txn(1'b0, 12'h040, '0, 6, 1'b1);
    chk("t4_line", resp_line, L1);
    chk("t4_ready_after_ack", 128'(req_ready), 128'(1));
    chk("t4_idle_after_ack",  128'(busy),      128'(0));
    run_txn(1'b0, 12'h040, '0, 0, 1'b0);
    chk("t4_second_resp_cycle", 128'(resp_cyc), 128'(8));

    // 5: reset during the word-2 write
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 12'h200; req_wdata = W5;
    slot();
    req_valid = 1'b0;
    repeat (5) slot();
    chk("t5_w2_csn",  128'(csn),    128'(0));
    chk("t5_w2_wen",  128'(wen),    128'(0));
    chk("t5_w2_addr", 128'(d_addr), 128'(12'h208));
    rst = 1'b1;
    #1;
    chk("t5_rst_csn",  128'(csn),  128'(1));
    chk("t5_rst_wen",  128'(wen),  128'(1));
    chk("t5_rst_busy", 128'(busy), 128'(0));
    slot();
    rst = 1'b0;
    chk("t5_mem0", 128'(mem[128]), 128'(32'h12345678));
    chk("t5_mem1", 128'(mem[129]), 128'(32'h9ABCDEF0));
    chk("t5_mem2", 128'(mem[130]), 128'(32'h55550002));
    chk("t5_mem3", 128'(mem[131]), 128'(32'h55550003));
    slot();
    chk("t5_ready", 128'(req_ready), 128'(1));
    run_txn(1'b0, 12'h040, '0, 0, 1'b0);
    chk("t5_resp_cycle", 128'(resp_cyc), 128'(8));
    chk("t5_line", resp_line, L1);

    // 6: back-to-back read / write / read of 0x100
    run_txn(1'b0, 12'h100, '0, 0, 1'b0);
    chk("t6_first", resp_line, 128'hB0000000_B0000001_B0000002_B0000003);
    run_txn(1'b1, 12'h100, W6, 0, 1'b0);
    run_txn(1'b0, 12'h100, '0, 0, 1'b0);
    chk("t6_third", resp_line, W6);
    slot();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
